mbinit_sb_tx_arbiter: RTL and testbench

- Shares the single sideband TX message port among the MBINIT substate wrappers: PARAM, CAL, REPAIRCLK, REPAIRVAL, REVERSALMB and REPAIRMB.
- Grants requesters round-robin and latches the winner's 4-bit encoded message and 16-bit data.
- Issues one valid pulse to the SB, tracks the SB busy handshake, and returns a per-requester falling-edge-busy pulse; the wrappers use this pulse to advance their FSMs.
- Sits between the MBINIT wrappers and the SB packet encoder.

---
 rtl/mbinit_pkg.sv | 24 ++
 rtl/mbinit_rr_picker.sv | 32 +++
 rtl/mbinit_sb_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mbinit_sb_tx_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: SB message geometry, requester indices and the
// sideband TX arbiter state encoding.
package mbinit_pkg;

    localparam int SB_MSG_W  = 4;
    localparam int SB_DATA_W = 16;

    localparam int REQ_PARAM      = 0;
    localparam int REQ_CAL        = 1;
    localparam int REQ_REPAIRCLK  = 2;
    localparam int REQ_REPAIRVAL  = 3;
    localparam int REQ_REVERSALMB = 4;
    localparam int REQ_REPAIRMB   = 5;
    localparam int MBINIT_N_REQ   = REQ_REPAIRMB + 1;

    typedef enum logic [2:0] {
        ARB_IDLE        = 3'd0,
        ARB_ISSUE       = 3'd1,
        ARB_WAIT_ACCEPT = 3'd2,
        ARB_WAIT_DONE   = 3'd3,
        ARB_RELEASE     = 3'd4
    } arb_state_e;

endpackage

// File: rtl/mbinit_rr_picker.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping at N_REQ-1. Shared by the TX and RX-side arbiters.
module mbinit_rr_picker #(
    parameter  int N_REQ = 6,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             found_o
);

    logic [IW-1:0] k;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_o = 1'b0;
        k       = ptr_i;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_o && req_i[k]) begin
                gnt_o[k] = 1'b1;
                idx_o    = k;
                found_o  = 1'b1;
            end
            // Explicit wrap so non-power-of-two N_REQ stays in range.
            k = (k == IW'(N_REQ - 1)) ? '0 : k + IW'(1);
        end
    end

endmodule

// File: rtl/mbinit_sb_tx_arbiter.sv
// Round-robin owner of the sideband TX port for the MBINIT substate wrappers:
// issues one message, tracks the SB busy handshake, returns a completion pulse.
module mbinit_sb_tx_arbiter
    import mbinit_pkg::*;
#(
    parameter int N_REQ     = MBINIT_N_REQ,
    parameter int MSG_W     = SB_MSG_W,
    parameter int DATA_W    = SB_DATA_W,
    parameter int ACCEPT_TO = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_ltsm_in_reset,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*MSG_W-1:0]    i_req_msg,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    input  logic [N_REQ-1:0]          i_req_data_valid,
    input  logic                      i_SB_Busy,
    output logic                      o_tx_msg_valid,
    output logic [MSG_W-1:0]          o_TX_SbMessage,
    output logic [DATA_W-1:0]         o_tx_data_bus,
    output logic                      o_tx_data_valid,
    output logic [N_REQ-1:0]          o_grant,
    output logic [N_REQ-1:0]          o_falling_edge_busy,
    output logic                      o_arb_error
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (ACCEPT_TO > 1) ? $clog2(ACCEPT_TO) : 1;

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               dv_q, dv_d;
    logic               txv_q, txv_d;
    logic               busy_prev_q;

    logic [N_REQ-1:0]   pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_found;
    logic               busy_fall;
    logic [IW-1:0]      ptr_after_owner;

    mbinit_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_i   (i_req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign busy_fall       = busy_prev_q & ~i_SB_Busy;
    assign ptr_after_owner = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);

    always_comb begin
        state_d             = state_q;
        ptr_d               = ptr_q;
        owner_d             = owner_q;
        cnt_d               = cnt_q;
        grant_d             = grant_q;
        msg_d               = msg_q;
        data_d              = data_q;
        dv_d                = dv_q;
        txv_d               = 1'b0;
        o_falling_edge_busy = '0;
        o_arb_error         = 1'b0;

        if (i_ltsm_in_reset) begin
            state_d = ARB_IDLE;
            ptr_d   = '0;
            cnt_d   = '0;
            grant_d = '0;
            msg_d   = '0;
            data_d  = '0;
            dv_d    = 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    // Never hand a new message to an encoder that is still busy.
                    if (pick_found && !i_SB_Busy) begin
                        grant_d = pick_gnt;
                        owner_d = pick_idx;
                        msg_d   = i_req_msg[int'(pick_idx)*MSG_W +: MSG_W];
                        data_d  = i_req_data[int'(pick_idx)*DATA_W +: DATA_W];
                        dv_d    = i_req_data_valid[pick_idx];
                        state_d = ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    txv_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ARB_WAIT_ACCEPT;
                end
                ARB_WAIT_ACCEPT: begin
                    if (i_SB_Busy) begin
                        state_d = ARB_WAIT_DONE;
                    end else if (cnt_q == CW'(ACCEPT_TO - 1)) begin
                        o_arb_error = 1'b1;
                        grant_d     = '0;
                        msg_d       = '0;
                        data_d      = '0;
                        dv_d        = 1'b0;
                        ptr_d       = ptr_after_owner;
                        state_d     = ARB_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ARB_WAIT_DONE: begin
                    if (busy_fall) begin
                        o_falling_edge_busy = grant_q;
                        grant_d             = '0;
                        msg_d               = '0;
                        data_d              = '0;
                        dv_d                = 1'b0;
                        ptr_d               = ptr_after_owner;
                        state_d             = ARB_RELEASE;
                    end
                end
                ARB_RELEASE: state_d = ARB_IDLE;
                default:     state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            msg_q       <= '0;
            data_q      <= '0;
            dv_q        <= 1'b0;
            txv_q       <= 1'b0;
            busy_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            msg_q       <= msg_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            txv_q       <= txv_d;
            busy_prev_q <= i_SB_Busy;
        end
    end

    assign o_tx_msg_valid  = txv_q;
    assign o_TX_SbMessage  = msg_q;
    assign o_tx_data_bus   = data_q;
    assign o_tx_data_valid = dv_q;
    assign o_grant         = grant_q;

endmodule

// File: tb/tb_mbinit_sb_tx_arbiter.sv
// Directed bench for the MBINIT sideband TX arbiter: issue latency, fairness,
// accept timeout, busy gating, LTSM flush and asynchronous reset.
module tb_mbinit_sb_tx_arbiter;

    localparam int N  = 6;
    localparam int MW = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ltsm;
    logic [N-1:0]    req_valid;
    logic [N*MW-1:0] req_msg;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_dv;
    logic            busy;
    logic            txv;
    logic [MW-1:0]   tx_msg;
    logic [DW-1:0]   tx_data;
    logic            tx_dv;
    logic [N-1:0]    grant;
    logic [N-1:0]    feb;
    logic            err;

    int checks = 0;
    int errors = 0;

    mbinit_sb_tx_arbiter #(.N_REQ(N), .MSG_W(MW), .DATA_W(DW), .ACCEPT_TO(8)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_ltsm_in_reset     (ltsm),
        .i_req_valid         (req_valid),
        .i_req_msg           (req_msg),
        .i_req_data          (req_data),
        .i_req_data_valid    (req_dv),
        .i_SB_Busy           (busy),
        .o_tx_msg_valid      (txv),
        .o_TX_SbMessage      (tx_msg),
        .o_tx_data_bus       (tx_data),
        .o_tx_data_valid     (tx_dv),
        .o_grant             (grant),
        .o_falling_edge_busy (feb),
        .o_arb_error         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ltsm      = 1'b0;
        req_valid = '0;
        req_msg   = '0;
        req_data  = '0;
        req_dv    = '0;
        busy      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({txv, tx_msg, tx_data, tx_dv, feb, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got txv=%b msg=%h data=%h dv=%b feb=%b err=%b, want all 0",
                     txv, tx_msg, tx_data, tx_dv, feb, err);
        end
        checks++;
        if (grant !== 6'b000000) begin
            errors++;
            $display("FAIL reset_grant: got %b want 000000", grant);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 6'b010000;
        req_msg[4*MW +: MW]  = 4'hA;
        req_data[4*DW +: DW] = 16'h00F3;
        req_dv[4]            = 1'b1;
        tick();
        checks++;
        if (grant !== 6'b010000 || txv !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: got grant=%b txv=%b want 010000/0", grant, txv);
        end
        // Payload changes after grant must not reach the SB.
        req_msg[4*MW +: MW]  = 4'h5;
        req_data[4*DW +: DW] = 16'h1234;
        tick();
        checks++;
        if (txv !== 1'b1 || tx_msg !== 4'hA || tx_data !== 16'h00F3 || tx_dv !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: got txv=%b msg=%h data=%h dv=%b want 1/a/00f3/1",
                     txv, tx_msg, tx_data, tx_dv);
        end
        req_valid = '0;
        busy = 1'b1;
        tick();
        checks++;
        if (txv !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: got txv=%b want 0", txv);
        end
        repeat (4) tick();
        checks++;
        if (feb !== 6'b000000 || tx_msg !== 4'hA) begin
            errors++;
            $display("FAIL single_busy_hold: got feb=%b msg=%h want 000000/a", feb, tx_msg);
        end
        busy = 1'b0;
        #1;
        checks++;
        if (feb !== 6'b010000) begin
            errors++;
            $display("FAIL single_falling_edge: got %b want 010000", feb);
        end
        tick();
        checks++;
        if (feb !== 6'b000000 || grant !== 6'b000000 || tx_msg !== 4'h0 || tx_data !== 16'h0) begin
            errors++;
            $display("FAIL single_release: got feb=%b grant=%b msg=%h data=%h want all 0",
                     feb, grant, tx_msg, tx_data);
        end
    endtask

    task automatic test_fairness();
        int served [N];
        logic seen;
        logic [N-1:0] exp_g;
        do_reset();
        for (int k = 0; k < N; k++) begin
            served[k] = 0;
            req_msg[k*MW +: MW]  = MW'(k + 1);
            req_data[k*DW +: DW] = DW'(16'h1000 + k);
        end
        req_valid = 6'b111111;
        for (int t = 0; t < 12; t++) begin
            seen = 1'b0;
            for (int c = 0; c < 12 && !seen; c++) begin
                tick();
                seen = txv;
            end
            exp_g = 6'b000001 << (t % N);
            checks++;
            if (!seen || grant !== exp_g || tx_msg !== MW'((t % N) + 1)) begin
                errors++;
                $display("FAIL fair_grant_%0d: got seen=%b grant=%b msg=%h want 1/%b/%h",
                         t, seen, grant, tx_msg, exp_g, MW'((t % N) + 1));
            end
            for (int k = 0; k < N; k++) if (grant[k]) served[k]++;
            busy = 1'b1;
            tick();
            tick();
            busy = 1'b0;
            #1;
            checks++;
            if (feb !== exp_g) begin
                errors++;
                $display("FAIL fair_done_%0d: got feb=%b want %b", t, feb, exp_g);
            end
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (served[k] !== 2) begin
                errors++;
                $display("FAIL fair_count_%0d: got %0d want 2", k, served[k]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        logic [N-1:0] g;
        do_reset();
        req_valid = 6'b000100;
        tick();
        checks++;
        if (grant !== 6'b000100) begin
            errors++;
            $display("FAIL to_grant: got %b want 000100", grant);
        end
        for (int c = 1; c <= 7; c++) begin
            tick();
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL to_early_%0d: got err=%b want 0", c, err);
            end
        end
        tick();
        checks++;
        if (err !== 1'b1 || feb !== 6'b000000) begin
            errors++;
            $display("FAIL to_error: got err=%b feb=%b want 1/000000", err, feb);
        end
        tick();
        checks++;
        if (err !== 1'b0 || grant !== 6'b000000 || feb !== 6'b000000) begin
            errors++;
            $display("FAIL to_release: got err=%b grant=%b feb=%b want 0/000000/000000", err, grant, feb);
        end
        req_valid = 6'b001001;
        g = '0;
        for (int c = 0; c < 6 && g == '0; c++) begin
            tick();
            g = grant;
        end
        checks++;
        if (g !== 6'b001000) begin
            errors++;
            $display("FAIL to_next_ptr: got %b want 001000", g);
        end
        req_valid = '0;
    endtask

    task automatic test_busy_idle();
        do_reset();
        busy = 1'b1;
        req_valid = 6'b000010;
        req_msg[1*MW +: MW] = 4'h3;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (txv !== 1'b0 || grant !== 6'b000000) begin
                errors++;
                $display("FAIL bi_hold_%0d: got txv=%b grant=%b want 0/000000", c, txv, grant);
            end
        end
        busy = 1'b0;
        #1;
        checks++;
        if (feb !== 6'b000000) begin
            errors++;
            $display("FAIL bi_stray_fall: got %b want 000000", feb);
        end
        tick();
        checks++;
        if (grant !== 6'b000010 || txv !== 1'b0) begin
            errors++;
            $display("FAIL bi_grant: got grant=%b txv=%b want 000010/0", grant, txv);
        end
        tick();
        checks++;
        if (txv !== 1'b1 || tx_msg !== 4'h3) begin
            errors++;
            $display("FAIL bi_issue: got txv=%b msg=%h want 1/3", txv, tx_msg);
        end
        req_valid = '0;
    endtask

    task automatic test_flush();
        do_reset();
        req_valid = 6'b010000;
        req_msg[4*MW +: MW] = 4'h7;
        tick();
        tick();
        busy = 1'b1;
        tick();
        checks++;
        if (grant !== 6'b010000) begin
            errors++;
            $display("FAIL fl_owner: got %b want 010000", grant);
        end
        ltsm = 1'b1;
        tick();
        checks++;
        if (grant !== 6'b000000 || tx_msg !== 4'h0) begin
            errors++;
            $display("FAIL fl_clear: got grant=%b msg=%h want 000000/0", grant, tx_msg);
        end
        tick();
        busy = 1'b0;
        #1;
        checks++;
        if (feb !== 6'b000000 || err !== 1'b0) begin
            errors++;
            $display("FAIL fl_no_pulse: got feb=%b err=%b want 000000/0", feb, err);
        end
        tick();
        checks++;
        if (grant !== 6'b000000) begin
            errors++;
            $display("FAIL fl_ignore_req: got %b want 000000", grant);
        end
        ltsm = 1'b0;
        req_valid = 6'b101000;
        tick();
        checks++;
        if (grant !== 6'b001000) begin
            errors++;
            $display("FAIL fl_regrant: got %b want 001000", grant);
        end
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 6'b000001;
        req_msg[0 +: MW]  = 4'hC;
        req_data[0 +: DW] = 16'hBEEF;
        req_dv[0]         = 1'b1;
        tick();
        tick();
        checks++;
        if (txv !== 1'b1 || grant !== 6'b000001 || tx_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL ar_setup: got txv=%b grant=%b data=%h want 1/000001/beef", txv, grant, tx_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({txv, tx_msg, tx_data, tx_dv, grant, feb, err} !== '0) begin
            errors++;
            $display("FAIL ar_outputs: got txv=%b msg=%h data=%h dv=%b grant=%b feb=%b err=%b want all 0",
                     txv, tx_msg, tx_data, tx_dv, grant, feb, err);
        end
        req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_busy_idle();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
